// File: rtl/fp_unit_arbiter.sv
// Shares one FP adder and one FP multiplier among NREQ requesters, each unit behind its own round-robin channel.
// Grant/go one cycle after request, response one cycle after unit finish; a WAIT reaching TIMEOUT aborts with err_valid.
module fp_unit_arbiter #(
  parameter int DBL_WIDTH = 64,
  parameter int NREQ      = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           req_op,
  input  logic [NREQ*DBL_WIDTH-1:0] req_a,
  input  logic [NREQ*DBL_WIDTH-1:0] req_b,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [NREQ*DBL_WIDTH-1:0] rsp_data,
  output logic                      err_valid,
  output logic [$clog2(NREQ)-1:0]   err_id,
  output logic                      add_go,
  output logic                      mul_go,
  output logic [DBL_WIDTH-1:0]      add_a,
  output logic [DBL_WIDTH-1:0]      add_b,
  output logic [DBL_WIDTH-1:0]      mul_a,
  output logic [DBL_WIDTH-1:0]      mul_b,
  input  logic                      add_finish,
  input  logic                      mul_finish,
  input  logic [DBL_WIDTH-1:0]      add_r,
  input  logic [DBL_WIDTH-1:0]      mul_r
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_VAL  = CW'(TIMEOUT);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  // Index 0 is the ADD channel, index 1 the MUL channel.
  state_t                         state  [2];
  logic [IDW-1:0]                 rr_ptr [2];
  logic [IDW-1:0]                 cur_id [2];
  logic [CW-1:0]                  cnt    [2];
  logic [DBL_WIDTH-1:0]           op_a   [2];
  logic [DBL_WIDTH-1:0]           op_b   [2];
  logic [1:0]                     go_q;
  logic                           err_pend;
  logic [IDW-1:0]                 pend_id;
  logic [NREQ-1:0][DBL_WIDTH-1:0] a_v;
  logic [NREQ-1:0][DBL_WIDTH-1:0] b_v;
  logic [NREQ-1:0][DBL_WIDTH-1:0] rsp_q;
  logic [NREQ-1:0]                cand   [2];
  logic [IDW-1:0]                 sel_id [2];
  logic [DBL_WIDTH-1:0]           res    [2];
  logic [1:0]                     sel_vld;
  logic [1:0]                     fin;
  logic [1:0]                     tmo;
  logic [IDW-1:0]                 idx;

  assign a_v     = req_a;
  assign b_v     = req_b;
  assign cand[0] = req & ~req_op;
  assign cand[1] = req & req_op;
  assign fin     = {mul_finish, add_finish};
  assign res[0]  = add_r;
  assign res[1]  = mul_r;

  always_comb begin
    idx     = '0;
    sel_vld = '0;
    tmo     = '0;
    for (int c = 0; c < 2; c++) begin
      sel_id[c] = '0;
      // Scan downward so the last hit is the first requester at or after rr_ptr.
      for (int k = NREQ - 1; k >= 0; k--) begin
        idx = IDW'((int'(rr_ptr[c]) + k) % NREQ);
        if (cand[c][idx]) begin
          sel_vld[c] = 1'b1;
          sel_id[c]  = idx;
        end
      end
      if (state[c] != ST_IDLE) sel_vld[c] = 1'b0;
      tmo[c] = (state[c] == ST_WAIT) && !fin[c] && (cnt[c] == TO_VAL);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        state[c]  <= ST_IDLE;
        rr_ptr[c] <= '0;
        cur_id[c] <= '0;
        cnt[c]    <= '0;
        op_a[c]   <= '0;
        op_b[c]   <= '0;
      end
      go_q      <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_q     <= '0;
      err_valid <= 1'b0;
      err_id    <= '0;
      err_pend  <= 1'b0;
      pend_id   <= '0;
    end else begin
      gnt       <= '0;
      go_q      <= '0;
      rsp_valid <= '0;
      for (int c = 0; c < 2; c++) begin
        case (state[c])
          ST_IDLE: begin
            if (sel_vld[c]) begin
              gnt[sel_id[c]] <= 1'b1;
              go_q[c]        <= 1'b1;
              op_a[c]        <= a_v[sel_id[c]];
              op_b[c]        <= b_v[sel_id[c]];
              cur_id[c]      <= sel_id[c];
              cnt[c]         <= '0;
              state[c]       <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (fin[c]) begin
              rsp_valid[cur_id[c]] <= 1'b1;
              rsp_q[cur_id[c]]     <= res[c];
            end
            // Finish and timeout both release the channel; finish wins on a tie.
            if (fin[c] || cnt[c] == TO_VAL) begin
              rr_ptr[c] <= (cur_id[c] == LAST_ID) ? '0 : cur_id[c] + 1'b1;
              state[c]  <= ST_IDLE;
            end else begin
              cnt[c] <= cnt[c] + 1'b1;
            end
          end
          default: state[c] <= ST_IDLE;
        endcase
      end

      // Simultaneous timeouts: ADD reports now, MUL is parked one cycle.
      err_valid <= 1'b0;
      if (tmo[0]) begin
        err_valid <= 1'b1;
        err_id    <= cur_id[0];
        if (tmo[1]) begin
          err_pend <= 1'b1;
          pend_id  <= cur_id[1];
        end
      end else if (err_pend) begin
        err_valid <= 1'b1;
        err_id    <= pend_id;
        err_pend  <= 1'b0;
      end else if (tmo[1]) begin
        err_valid <= 1'b1;
        err_id    <= cur_id[1];
      end
    end
  end

  assign rsp_data = rsp_q;
  assign add_go   = go_q[0];
  assign mul_go   = go_q[1];
  assign add_a    = op_a[0];
  assign add_b    = op_b[0];
  assign mul_a    = op_a[1];
  assign mul_b    = op_b[1];

endmodule

// File: doc/fp_unit_arbiter.md
FP_UNIT_ARBITER -- requirements
Module: fp_unit_arbiter

Interface
REQ-001 Parameter DBL_WIDTH, default 64: operand/result width in bits.
REQ-002 Parameter NREQ, default 4: number of requester ports.
REQ-003 Parameter TIMEOUT, default 255: maximum WAIT cycles before abort.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset.
REQ-005 Ports, one per line:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req  in  NREQ  per-requester request level
- req_op  in  NREQ  per-requester op select: 0=add, 1=mul
- req_a  in  NREQ*DBL_WIDTH  operand A, requester i at slice i
- req_b  in  NREQ*DBL_WIDTH  operand B, requester i at slice i
- gnt  out  NREQ  one-cycle grant pulse
- rsp_valid  out  NREQ  one-cycle result pulse
- rsp_data  out  NREQ*DBL_WIDTH  registered result, slice i
- err_valid  out  1  one-cycle timeout pulse
- err_id  out  $clog2(NREQ)  requester index of the aborted op
- add_go, mul_go  out  1  start pulse to adder/multiplier
- add_a, add_b, mul_a, mul_b  out  DBL_WIDTH  unit operands
- add_finish, mul_finish  in  1  unit completion pulse
- add_r, mul_r  in  DBL_WIDTH  unit result, valid with finish

Function
REQ-006 Two independent channels (ADD, MUL); each SHALL run its own FSM, round-robin pointer and timeout counter.
REQ-007 Channel FSM states SHALL be IDLE and WAIT only.
REQ-008 In IDLE at cycle t, a channel SHALL select the first i, searching upward from its rr_ptr modulo NREQ, with req[i]=1 and req_op[i] matching the channel.
REQ-009 On a selection at t, at t+1: gnt[i]=1, go=1, unit a/b = req_a/req_b slice i as sampled at t, state=WAIT.
REQ-010 go and gnt SHALL be high exactly one cycle per issue; unit operands SHALL hold until the next issue.
REQ-011 In WAIT, req SHALL be ignored by that channel; in IDLE, finish SHALL be ignored.
REQ-012 finish sampled in WAIT at cycle t SHALL produce, at t+1: rsp_valid[i]=1, rsp_data slice i = result, rr_ptr=(i+1) mod NREQ, state=IDLE.
REQ-013 rsp_data slice i SHALL hold until that requester's next response.
REQ-014 The earliest next issue on a channel after finish at t SHALL be t+2.
REQ-015 Requesters SHALL drop req the cycle after gnt; a req still high when the channel re-enters IDLE is a new request.
REQ-016 ADD and MUL grants to different requesters in the same cycle SHALL both be issued.
REQ-017 When both channels respond in the same cycle, both rsp_valid bits and both slices SHALL update.
REQ-018 The timeout counter SHALL clear on issue and increment each WAIT cycle; at count==TIMEOUT without finish: err_valid=1, err_id=i, no rsp_valid, rr_ptr advances, state=IDLE.
REQ-019 If finish coincides with count==TIMEOUT, finish SHALL win and no error SHALL be raised.
REQ-020 If both channels time out in the same cycle, ADD SHALL report first and MUL SHALL report in the following cycle.

Reset
REQ-021 With rst_n=0 at a clock edge: both states=IDLE, rr_ptrs=0, counters=0; gnt, rsp_valid, go, err_valid, err_id, rsp_data, and unit operands SHALL all be 0.
REQ-022 Reset mid-WAIT SHALL discard the in-flight op; a finish arriving after reset SHALL be ignored.

Verification
REQ-023 req[0]=1, op=add, a=0x3FF0000000000000, b=0x4000000000000000; add_finish 3 cycles after add_go with add_r=0x4008000000000000 -> gnt[0] and add_go one cycle after req; rsp_valid[0] one cycle after finish; slice 0=0x4008000000000000.
REQ-024 All four requesters held on mul, finish 2 cycles after each go -> grant order 0,1,2,3, one grant every 4 cycles; rr_ptr returns to 0.
REQ-025 req[1] add and req[2] mul in the same cycle -> gnt=0b0110 and add_go=mul_go=1 in the same cycle; independent responses.
REQ-026 TIMEOUT=8, req[3] mul, no finish -> err_valid=1, err_id=3 after 8 WAIT cycles; no rsp_valid; a later req[3] is re-granted. Repeat with finish on cycle 8 -> rsp_valid[3], no err.
REQ-027 rst_n low for 1 cycle during ADD WAIT, then add_finish -> no rsp_valid; all outputs 0; the next req[0] is granted normally.
